nibble_serial_adder: RTL and testbench

- Multi-word adder that adds two NIBBLES*4-bit operands one nibble per clock.
- It drives a 4-bit ripple-carry adder stage with one operand nibble pair plus the registered carry each cycle, and captures that stage's sum nibble and carry-out.
- It is the sequencing stage directly upstream and downstream of the 4-bit adder. Wide additions reuse one 4-bit datapath instead of a wide ripple chain.

---
 rtl/nibble_serial_adder_pkg.sv | 16 +
 rtl/nibble_serial_adder_add4.sv | 22 ++
 rtl/nibble_serial_adder.sv | 137 +++++++++++++
 tb/tb_nibble_serial_adder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and state encoding for the nibble-serial adder.
// No logic of its own.
// Nothing here affects timing or flow control.
package nibble_serial_adder_pkg;

  // Width of one digit processed per clock
  localparam int NIBBLE_W = 4;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serial_adder_add4.sv
// Purely combinational 4-bit ripple adder; also exposes the carry into bit 3.
// Latency: zero cycles.
// No flow control: every input change propagates directly to the outputs.
module add4_core (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);

  logic [3:0] low;

  // The low three bits are added as a 4-bit value so that bit 3 of the result
  // is exactly the carry into the top bit; the top bit is then finished by hand.
  assign low = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, ci};
  assign c3  = low[3];
  assign s   = {a[3] ^ b[3] ^ c3, low[2:0]};
  assign co  = (a[3] & b[3]) | (c3 & (a[3] ^ b[3]));

endmodule

// File: rtl/nibble_serial_adder.sv
// Adds two NIBBLES*4-bit operands one nibble per clock through a shared 4-bit adder.
// Latency: start accepted at edge k -> done pulse in the cycle after edge k+NIBBLES.
// start is ignored while busy; start in the DONE cycle is accepted for back-to-back use.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [NIBBLE_W*NIBBLES-1:0]  a,
  input  logic [NIBBLE_W*NIBBLES-1:0]  b,
  input  logic                         cin,
  output logic                         busy,
  output logic                         done,
  output logic [NIBBLE_W*NIBBLES-1:0]  sum,
  output logic                         cout,
  output logic                         ovf
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     wsum_q, wsum_d;
  logic [W-1:0]     sum_q, sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [IDX_W+1:0] base;
  logic             last;
  logic [3:0]       add_s;
  logic             add_co;
  logic             add_c3;

  // Bit offset of the nibble currently being processed
  assign base = {idx_q, 2'b00};
  assign last = (idx_q == IDX_W'(NIBBLES - 1));

  add4_core u_add4 (
    .a  (a_q[base +: NIBBLE_W]),
    .b  (b_q[base +: NIBBLE_W]),
    .ci (carry_q),
    .s  (add_s),
    .co (add_co),
    .c3 (add_c3)
  );

  // Next-state logic: operand capture, per-nibble accumulation and completion
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    wsum_d  = wsum_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        wsum_d[base +: NIBBLE_W] = add_s;
        carry_d                  = add_co;
        if (last) begin
          // Publish the whole word at once so partial nibbles never show on sum
          sum_d   = wsum_d;
          cout_d  = add_co;
          ovf_d   = add_c3 ^ add_co;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Status outputs are registered straight from the next state
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      wsum_q  <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wsum_q  <= wsum_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench: table-driven directed vectors at NIBBLES=4, hand-written
// multi-cycle sequences, and random operands at NIBBLES=1/4/8 against a W-bit add.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cin_i = 1'b0;
  logic [31:0] a_w = '0;
  logic [31:0] b_w = '0;

  logic        busy1, done1, cout1, ovf1;
  logic [3:0]  sum1;
  logic        busy4, done4, cout4, ovf4;
  logic [15:0] sum4;
  logic        busy8, done8, cout8, ovf8;
  logic [31:0] sum8;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a_w[3:0]), .b(b_w[3:0]), .cin(cin_i),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1));

  nibble_serial_adder #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a_w[15:0]), .b(b_w[15:0]), .cin(cin_i),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4));

  nibble_serial_adder #(.NIBBLES(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a_w), .b(b_w), .cin(cin_i),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

  logic [2:0]  done_v;
  logic [2:0]  cout_v;
  logic [2:0]  ovf_v;
  logic [31:0] sum_v [3];
  assign done_v   = {done8, done4, done1};
  assign cout_v   = {cout8, cout4, cout1};
  assign ovf_v    = {ovf8, ovf4, ovf1};
  assign sum_v[0] = {28'd0, sum1};
  assign sum_v[1] = {16'd0, sum4};
  assign sum_v[2] = sum8;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain W-bit arithmetic; returns {ovf, cout, sum}
  function automatic logic [33:0] ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic ci);
    logic [63:0] m, t, s;
    logic sa, sb, ss, co;
    m  = (64'd1 << w) - 64'd1;
    t  = ({32'd0, a} & m) + ({32'd0, b} & m) + {63'd0, ci};
    s  = t & m;
    co = t[w];
    sa = a[w-1];
    sb = b[w-1];
    ss = s[w-1];
    return {(sa == sb) && (ss != sa), co, s[31:0]};
  endfunction

  // One NIBBLES=4 addition with latency, busy length and result checks
  task automatic run4(input vec_t v);
    int c;
    int busy_cnt;
    bit got;
    a_w   = {16'd0, v.a};
    b_w   = {16'd0, v.b};
    cin_i = v.ci;
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 0; busy_cnt = 0; got = 0;
    while (c < 20) begin
      if (busy4) busy_cnt++;
      if (done4) begin
        got = 1;
        break;
      end
      tick();
      c++;
    end
    check("run4_done_seen", 64'(got), 64'd1);
    check("run4_latency", 64'(c), 64'd4);
    check("run4_busy_cycles", 64'(busy_cnt), 64'd4);
    check("run4_sum", 64'(sum4), 64'(v.s));
    check("run4_cout", 64'(cout4), 64'(v.co));
    check("run4_ovf", 64'(ovf4), 64'(v.ov));
    tick();
    check("run4_done_one_cycle", 64'(done4), 64'd0);
    repeat (10) tick();
  endtask

  // Same operands to all three widths; each checked against the reference model
  task automatic sweep(input logic [31:0] a, input logic [31:0] b, input logic ci);
    int seen [3];
    int at [3];
    logic [33:0] r;
    for (int i = 0; i < 3; i++) begin
      seen[i] = 0;
      at[i] = -1;
    end
    a_w   = a;
    b_w   = b;
    cin_i = ci;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (done_v[i]) begin
          seen[i]++;
          at[i] = c;
          r = ref_add(4 * ((i == 0) ? 1 : (i == 1) ? 4 : 8), a, b, ci);
          check("rand_sum", 64'(sum_v[i]), 64'(r[31:0]));
          check("rand_cout", 64'(cout_v[i]), 64'(r[32]));
          check("rand_ovf", 64'(ovf_v[i]), 64'(r[33]));
        end
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      check("rand_done_count", 64'(seen[i]), 64'd1);
      check("rand_latency", 64'(at[i]), 64'((i == 0) ? 1 : (i == 1) ? 4 : 8));
    end
  endtask

  initial begin
    int c;
    int dn;
    bit got;

    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[5] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    tbl[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};

    // Reset state
    repeat (3) tick();
    check("rst_busy", 64'(busy4), 64'd0);
    check("rst_done", 64'(done4), 64'd0);
    check("rst_sum", 64'(sum4), 64'd0);
    check("rst_cout", 64'(cout4), 64'd0);
    check("rst_ovf", 64'(ovf4), 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Directed table
    for (int i = 0; i < 7; i++) run4(tbl[i]);

    // start re-asserted during RUN is ignored
    a_w = 32'h0001; b_w = 32'h0001; cin_i = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a_w = 32'hFFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      if (done4) begin
        dn++;
        check("busy_ign_sum", 64'(sum4), 64'h0002);
        check("busy_ign_latency", 64'(k), 64'd2);
      end
      tick();
    end
    check("busy_ign_done_count", 64'(dn), 64'd1);

    // Reset mid-RUN aborts at once and produces no done
    a_w = 32'h1111; b_w = 32'h2222; cin_i = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy4), 64'd0);
    check("midrst_done", 64'(done4), 64'd0);
    check("midrst_sum", 64'(sum4), 64'd0);
    check("midrst_cout", 64'(cout4), 64'd0);
    check("midrst_ovf", 64'(ovf4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done4 || busy4) dn++;
    end
    check("midrst_no_activity", 64'(dn), 64'd0);
    run4(tbl[2]);

    // Back-to-back with start held high
    a_w = 32'h00FF; b_w = 32'h0001; cin_i = 1'b0;
    start = 1'b1;
    tick();
    c = 0; got = 0;
    while (c < 20) begin
      if (done4) begin
        got = 1;
        break;
      end
      tick();
      c++;
    end
    check("b2b_first_seen", 64'(got), 64'd1);
    check("b2b_first_latency", 64'(c), 64'd4);
    check("b2b_first_sum", 64'(sum4), 64'h0100);
    check("b2b_first_cout", 64'(cout4), 64'd0);
    a_w = 32'h8000; b_w = 32'h8000;
    tick();
    start = 1'b0;
    c = 1; got = 0;
    while (c < 20) begin
      if (done4) begin
        got = 1;
        break;
      end
      check("b2b_hold_sum", 64'(sum4), 64'h0100);
      tick();
      c++;
    end
    check("b2b_second_seen", 64'(got), 64'd1);
    check("b2b_period", 64'(c), 64'd5);
    check("b2b_second_sum", 64'(sum4), 64'h0000);
    check("b2b_second_cout", 64'(cout4), 64'd1);
    check("b2b_second_ovf", 64'(ovf4), 64'd1);
    repeat (12) tick();

    // Parameter sweep: NIBBLES=1 corner, then random operands on all widths
    sweep(32'h0000_000F, 32'h0000_0001, 1'b0);
    check("n1_sum", 64'(sum1), 64'h0);
    check("n1_cout", 64'(cout1), 64'd1);
    for (int n = 0; n < 40; n++) begin
      sweep($urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

endmodule
